// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - streams Brainfuck source into program RAM
// Filters comment bytes, tracks bracket depth, appends a 0x00 terminator and reports done/err.
module bf_program_loader #(
  parameter int size     = 512,
  parameter int addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [addrSize-1:0] ram_addr,
  output logic [7:0]          ram_data,
  output logic                ram_write_rq,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [addrSize-1:0] prog_len
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [addrSize-1:0] LAST_ADDR = addrSize'(size - 1);
  localparam logic [addrSize-1:0] ONE       = addrSize'(1);

  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  state_t                state_q, state_d;
  logic [addrSize-1:0]   ptr_q, ptr_d;
  logic [addrSize-1:0]   depth_q, depth_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  wr_q, wr_d;
  logic [addrSize-1:0]   addr_q, addr_d;
  logic [7:0]            data_q, data_d;

  logic                  accept;
  logic                  is_cmd;

  always_comb begin
    is_cmd = 1'b0;
    case (in_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  end

  assign busy     = (state_q == S_LOAD);
  assign in_ready = busy & ~reset;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    depth_d    = depth_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            if (depth_q != '0) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_UNCLOSED;
            end else begin
              // Terminator occupies ptr but is not counted in prog_len.
              wr_d    = 1'b1;
              addr_d  = ptr_q;
              data_d  = 8'h00;
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else if (is_cmd) begin
            if (in_data == 8'h5D && depth_q == '0) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_UNMATCHED;
            end else if (ptr_q == LAST_ADDR) begin
              // Last slot stays reserved for the terminator.
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end else begin
              wr_d   = 1'b1;
              addr_d = ptr_q;
              data_d = in_data;
              ptr_d  = ptr_q + ONE;
              if (in_data == 8'h5B) begin
                depth_d = depth_q + ONE;
              end else if (in_data == 8'h5D) begin
                depth_d = depth_q - ONE;
              end
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = S_LOAD;
          ptr_d      = '0;
          depth_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      depth_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      depth_q    <= depth_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign ram_write_rq = wr_q;
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign prog_len     = ptr_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - self-checking bench for bf_program_loader
// Table vectors, hand sequences for start/reset corners, and random streams against a byte-list model.
module tb_bf_program_loader;

  localparam int SIZE = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_write_rq;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW-1:0] prog_len;

  bf_program_loader #(.size(SIZE), .addrSize(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_write_rq(ram_write_rq),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stray = 0;

  logic [AW+7:0] got_q[$];
  logic [7:0]    src_q[$];
  logic [7:0]    exp_wr[$];
  int            exp_code, exp_len, exp_used;
  bit            exp_done;

  typedef struct {
    string src;
    bit    term;
    int    used;
    string wr;
    bit    twr;
    bit    dn;
    int    code;
    int    len;
  } tv_t;

  // Every strobe must follow an edge on which a byte was accepted.
  always @(posedge clk) begin : mon
    logic acc_edge;
    acc_edge = in_valid & in_ready;
    #1;
    if (ram_write_rq) begin
      got_q.push_back({ram_addr, ram_data});
      if (!acc_edge) stray++;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit is_cmd(logic [7:0] b);
    string cmds;
    cmds = "+-<>[],.";
    for (int i = 0; i < cmds.len(); i++) if (b == cmds[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: walk the byte list applying the loader rules directly.
  function automatic void model();
    int ptr, depth;
    ptr = 0; depth = 0;
    exp_wr.delete(); exp_code = 0; exp_done = 0; exp_used = 0;
    foreach (src_q[i]) begin
      logic [7:0] b;
      b = src_q[i];
      exp_used++;
      if (b == 8'h00) begin
        if (depth != 0) exp_code = 2;
        else begin exp_wr.push_back(8'h00); exp_done = 1; end
        break;
      end
      if (!is_cmd(b)) continue;
      if (b == 8'h5D && depth == 0) begin exp_code = 1; break; end
      if (ptr == SIZE - 1) begin exp_code = 3; break; end
      exp_wr.push_back(b);
      ptr++;
      if (b == 8'h5B) depth++;
      if (b == 8'h5D) depth--;
    end
    exp_len = ptr;
  endfunction

  task automatic send(input logic [7:0] b, output bit acc);
    for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    if (in_ready) begin
      @(negedge clk);
      acc = 1'b1;
    end else begin
      acc = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input string tag);
    int used;
    bit acc;
    got_q.delete();
    pulse_start();
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " cleared"}, {done, err, err_code, prog_len}, 0);
    used = 0;
    foreach (src_q[i]) begin
      send(src_q[i], acc);
      if (!acc) break;
      used++;
    end
    chk({tag, " accepted"}, used, exp_used);
    chk({tag, " done"}, done, exp_done);
    chk({tag, " err"}, err, exp_code != 0);
    chk({tag, " err_code"}, err_code, exp_code);
    chk({tag, " prog_len"}, prog_len, exp_len);
    chk({tag, " busy"}, busy, !(exp_done || exp_code != 0));
    chk({tag, " in_ready"}, in_ready, !(exp_done || exp_code != 0));
    chk({tag, " nwrites"}, got_q.size(), exp_wr.size());
    foreach (got_q[i]) begin
      if (i < exp_wr.size()) chk({tag, " write"}, got_q[i], {AW'(i), exp_wr[i]});
    end
  endtask

  tv_t tv[10];

  initial begin
    tv[0] = '{"+[->+<]",  1'b1, 8, "+[->+<]", 1'b1, 1'b1, 0, 7};
    tv[1] = '{"a+ b\n-",  1'b1, 7, "+-",      1'b1, 1'b1, 0, 2};
    tv[2] = '{"+]",       1'b0, 2, "+",       1'b0, 1'b0, 1, 1};
    tv[3] = '{"[[+]",     1'b1, 5, "[[+]",    1'b0, 1'b0, 2, 4};
    tv[4] = '{"++++++++", 1'b0, 8, "+++++++", 1'b0, 1'b0, 3, 7};
    tv[5] = '{"",         1'b1, 1, "",        1'b1, 1'b1, 0, 0};
    tv[6] = '{"]x",       1'b1, 1, "",        1'b0, 1'b0, 1, 0};
    tv[7] = '{"x,.[<>]",  1'b1, 8, ",.[<>]",  1'b1, 1'b1, 0, 6};
    tv[8] = '{"[+++++",   1'b1, 7, "[+++++",  1'b0, 1'b0, 2, 6};
    tv[9] = '{"+++++++",  1'b1, 8, "+++++++", 1'b1, 1'b1, 0, 7};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset outputs", {in_ready, ram_addr, ram_data, ram_write_rq, busy, done, err, err_code, prog_len}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle in_ready", in_ready, 0);

    foreach (tv[t]) begin
      string s;
      src_q.delete();
      s = tv[t].src;
      for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
      if (tv[t].term) src_q.push_back(8'h00);
      exp_wr.delete();
      s = tv[t].wr;
      for (int i = 0; i < s.len(); i++) exp_wr.push_back(s[i]);
      if (tv[t].twr) exp_wr.push_back(8'h00);
      exp_used = tv[t].used; exp_done = tv[t].dn; exp_code = tv[t].code; exp_len = tv[t].len;
      run_load($sformatf("tv%0d", t));
    end

    begin : start_in_load
      bit acc;
      got_q.delete();
      pulse_start();
      send(8'h2B, acc);
      pulse_start();
      send(8'h2D, acc);
      send(8'h00, acc);
      chk("start_ignored done", done, 1);
      chk("start_ignored prog_len", prog_len, 2);
      chk("start_ignored nwrites", got_q.size(), 3);
      if (got_q.size() == 3) begin
        chk("start_ignored w0", got_q[0], {AW'(0), 8'h2B});
        chk("start_ignored w1", got_q[1], {AW'(1), 8'h2D});
        chk("start_ignored w2", got_q[2], {AW'(2), 8'h00});
      end
    end

    begin : reset_mid_load
      bit acc;
      got_q.delete();
      pulse_start();
      for (int i = 0; i < 3; i++) send(8'h2B, acc);
      chk("rst writes_before", got_q.size(), 3);
      in_data = 8'h2D; in_valid = 1'b1; reset = 1'b1;
      @(negedge clk);
      chk("rst no_write", got_q.size(), 3);
      chk("rst outputs", {in_ready, ram_addr, ram_data, ram_write_rq, busy, done, err, err_code, prog_len}, 0);
      in_valid = 1'b0; reset = 1'b0;
      src_q.delete();
      src_q.push_back(8'h3E); src_q.push_back(8'h2E); src_q.push_back(8'h00);
      model();
      run_load("reload");
    end

    for (int n = 0; n < 60; n++) begin
      int len;
      src_q.delete();
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 19);
        case (r)
          0, 1, 2:  src_q.push_back(8'h5B);
          3, 4:     src_q.push_back(8'h5D);
          5, 6:     src_q.push_back(8'h2B);
          7:        src_q.push_back(8'h2D);
          8:        src_q.push_back(8'h3C);
          9:        src_q.push_back(8'h3E);
          10:       src_q.push_back(8'h2E);
          11:       src_q.push_back(8'h2C);
          12:       src_q.push_back(8'h00);
          13, 14:   src_q.push_back(8'h20);
          default:  src_q.push_back(8'($urandom_range(8'h80, 8'hFF)));
        endcase
      end
      src_q.push_back(8'h00);
      model();
      run_load($sformatf("rnd%0d", n));
    end

    chk("stray_writes", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
